// File: rtl/mult_io_pkg.sv
// Shared types and constants for the byte-serial multiplier I/O sequencer.
package mult_io_pkg;

  localparam int OP_W_DEF   = 10;
  localparam int PROD_W_DEF = 2 * OP_W_DEF;
  localparam int LD_BYTES   = 4;
  localparam int TX_BYTES   = 3;

  typedef enum logic [3:0] {
    LD_A0, LD_A1, LD_B0, LD_B1, CALC, WAIT, TX0, TX1, TX2
  } state_t;

  function automatic logic is_load(input state_t s);
    return (s == LD_A0) || (s == LD_A1) || (s == LD_B0) || (s == LD_B1);
  endfunction

  function automatic logic is_tx(input state_t s);
    return (s == TX0) || (s == TX1) || (s == TX2);
  endfunction

endpackage

// File: rtl/mult_io_sequencer.sv
// Loads two operands bytewise, waits for an external multiplier and streams the product out bytewise.
// Optional MULT_IO_PIPE_WAIT_EN inserts a WAIT state so the multiplier gets two cycles to settle.
module mult_io_sequencer
  import mult_io_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OP_W-1:0]     mul_a,
  output logic [OP_W-1:0]     mul_b,
  input  logic [2*OP_W-1:0]   mul_p,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int PROD_W = 2 * OP_W;
  localparam int HI_W   = OP_W - 8;
  localparam int EXT_W  = 8 * TX_BYTES;

  state_t            state_reg;
  logic [OP_W-1:0]   mul_a_reg;
  logic [OP_W-1:0]   mul_b_reg;
  logic [PROD_W-1:0] prod_reg;
  logic [EXT_W-1:0]  prod_ext;

  // ena gates every transition, so a low ena freezes state, operands and product alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LD_A0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      prod_reg  <= '0;
    end else if (ena) begin
      case (state_reg)
        LD_A0: if (in_valid) begin
          mul_a_reg[7:0] <= in_data;
          state_reg      <= LD_A1;
        end
        LD_A1: if (in_valid) begin
          mul_a_reg[OP_W-1:8] <= in_data[HI_W-1:0];
          state_reg           <= LD_B0;
        end
        LD_B0: if (in_valid) begin
          mul_b_reg[7:0] <= in_data;
          state_reg      <= LD_B1;
        end
        LD_B1: if (in_valid) begin
          mul_b_reg[OP_W-1:8] <= in_data[HI_W-1:0];
          state_reg           <= CALC;
        end
`ifdef MULT_IO_PIPE_WAIT_EN
        CALC: state_reg <= WAIT;
        WAIT: begin
          prod_reg  <= mul_p;
          state_reg <= TX0;
        end
`else
        CALC: begin
          prod_reg  <= mul_p;
          state_reg <= TX0;
        end
        WAIT: state_reg <= LD_A0;
`endif
        TX0: if (out_ready) state_reg <= TX1;
        TX1: if (out_ready) state_reg <= TX2;
        TX2: if (out_ready) state_reg <= LD_A0;
        default: state_reg <= LD_A0;
      endcase
    end
  end

  assign prod_ext = EXT_W'(prod_reg);

  // Output byte is a pure function of registered state, so it cannot glitch while stalled.
  always_comb begin
    out_data = 8'h00;
    case (state_reg)
      TX0:     out_data = prod_ext[7:0];
      TX1:     out_data = prod_ext[15:8];
      TX2:     out_data = prod_ext[23:16];
      default: out_data = 8'h00;
    endcase
  end

  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign in_ready  = is_load(state_reg) && ena;
  assign out_valid = is_tx(state_reg) && ena;
  assign busy      = (state_reg != LD_A0);

endmodule
